// File: rtl/proc_controller_v2.sv
// Fetch/decode/execute controller with req/ack instruction fetch, timeout fault,
// conditional relative branch and halt. All control outputs are registered Moore outputs.
module proc_controller_v2 #(
  parameter int PC_W     = 8,
  parameter int D_AW     = 8,
  parameter int FETCH_TO = 15
) (
  input  logic            Clk,
  input  logic            Reset,
  output logic [PC_W-1:0] Imem_addr,
  output logic            Imem_req,
  input  logic            Imem_ack,
  input  logic [15:0]     Imem_rdata,
  input  logic            ALU_Z,
  output logic [2:0]      ALU_s,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic            RF_s,
  output logic [D_AW-1:0] D_addr,
  output logic            D_wr,
  output logic            Halted,
  output logic            Fault,
  output logic [15:0]     IR_Out,
  output logic [PC_W-1:0] PC_Out,
  output logic [3:0]      State_Out
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_NOOP  = 4'd3,
    S_LOAD_A = 4'd4,  S_LOAD_B = 4'd5,  S_STORE  = 4'd6,  S_ADD   = 4'd7,
    S_SUB    = 4'd8,  S_JPZ    = 4'd9,  S_HALT   = 4'd10, S_FAULT = 4'd11
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(FETCH_TO - 1);

  state_t                  state, nxt_state;
  logic [PC_W-1:0]         pc, nxt_pc;
  logic [15:0]             ir, nxt_ir;
  logic [7:0]              wait_cnt, nxt_cnt;
  logic signed [PC_W+7:0]  jpz_off;

  assign jpz_off   = {{PC_W{ir[7]}}, ir[7:0]};
  assign Imem_addr = pc;
  assign PC_Out    = pc;
  assign IR_Out    = ir;
  assign State_Out = state;

  always_comb begin
    nxt_state = state;
    nxt_pc    = pc;
    nxt_ir    = ir;
    nxt_cnt   = wait_cnt;
    case (state)
      S_INIT:   nxt_state = S_FETCH;
      S_FETCH: begin
        // ack on the final permitted wait cycle still completes the fetch
        if (Imem_ack) begin
          nxt_ir    = Imem_rdata;
          nxt_pc    = pc + PC_W'(1);
          nxt_cnt   = '0;
          nxt_state = S_DECODE;
        end else if (wait_cnt == TO_LAST) begin
          nxt_cnt   = '0;
          nxt_state = S_FAULT;
        end else begin
          nxt_cnt   = wait_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        case (ir[15:12])
          4'h0:    nxt_state = S_NOOP;
          4'h1:    nxt_state = S_STORE;
          4'h2:    nxt_state = S_LOAD_A;
          4'h3:    nxt_state = S_ADD;
          4'h4:    nxt_state = S_SUB;
          4'h5:    nxt_state = S_HALT;
          4'h6:    nxt_state = S_JPZ;
          default: nxt_state = S_FAULT;
        endcase
      end
      S_LOAD_A: nxt_state = S_LOAD_B;
      S_JPZ: begin
        if (ALU_Z) nxt_pc = pc + jpz_off[PC_W-1:0];
        nxt_state = S_FETCH;
      end
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: nxt_state = S_FETCH;
      S_HALT:   nxt_state = S_HALT;
      S_FAULT:  nxt_state = S_FAULT;
      default:  nxt_state = S_FAULT;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_INIT;
      pc         <= '0;
      ir         <= '0;
      wait_cnt   <= '0;
      Imem_req   <= 1'b0;
      ALU_s      <= 3'b000;
      RF_Ra_addr <= '0;
      RF_Rb_addr <= '0;
      RF_W_addr  <= '0;
      RF_W_en    <= 1'b0;
      RF_s       <= 1'b0;
      D_addr     <= '0;
      D_wr       <= 1'b0;
      Halted     <= 1'b0;
      Fault      <= 1'b0;
    end else begin
      state      <= nxt_state;
      pc         <= nxt_pc;
      ir         <= nxt_ir;
      wait_cnt   <= nxt_cnt;
      Imem_req   <= (nxt_state == S_FETCH);
      RF_W_en    <= (nxt_state inside {S_LOAD_B, S_ADD, S_SUB});
      RF_s       <= (nxt_state == S_LOAD_B);
      D_wr       <= (nxt_state == S_STORE);
      Halted     <= (nxt_state inside {S_HALT, S_FAULT});
      Fault      <= (nxt_state == S_FAULT);
      ALU_s      <= (nxt_state == S_ADD) ? 3'b001 :
                    (nxt_state == S_SUB) ? 3'b010 : 3'b000;
      RF_Ra_addr <= (nxt_state == S_STORE) ? nxt_ir[3:0] :
                    (nxt_state inside {S_ADD, S_SUB, S_JPZ}) ? nxt_ir[11:8] : 4'h0;
      RF_Rb_addr <= (nxt_state inside {S_ADD, S_SUB}) ? nxt_ir[7:4] : 4'h0;
      RF_W_addr  <= (nxt_state inside {S_LOAD_B, S_ADD, S_SUB}) ? nxt_ir[3:0] : 4'h0;
      D_addr     <= (nxt_state inside {S_LOAD_A, S_LOAD_B, S_STORE}) ?
                    nxt_ir[4+D_AW-1:4] : '0;
    end
  end

endmodule
